// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory port among NUM_REQ requesters.
// Define DMEM_ARB_LOCK_EN to add req_lock and owner-only (LOCKED) arbitration.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_mask,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]              req_lock,
`endif
  output logic [NUM_REQ-1:0]              req_gnt,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [DATA_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic                            mem_we,
  output logic [DATA_WIDTH/8-1:0]         mem_mask,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int MASK_W = DATA_WIDTH / 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             gnt_any;

  // Round-robin search starting one past the last winner; in LOCKED only the owner qualifies.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
      if (!gnt_any && req_valid[cand] && (state == IDLE || cand == owner)) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    // Grant and memory outputs drop the moment reset asserts, not at the next edge.
    if (!arst_n) gnt_any = 1'b0;
  end

  always_comb begin
    req_gnt   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_mask  = '0;
    if (gnt_any) begin
      req_gnt[gnt_idx] = 1'b1;
      mem_addr         = req_addr[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      mem_wdata        = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      mem_we           = req_we[gnt_idx];
      mem_mask         = req_mask[int'(gnt_idx)*MASK_W +: MASK_W];
    end
  end

  // The memory returns read data one cycle after the address, so it is forwarded as-is.
  assign rsp_rdata = mem_rdata;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      owner     <= '0;
      last_gnt  <= IDX_W'(NUM_REQ - 1);
      rsp_valid <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rsp_valid <= '0;
      if (gnt_any) begin
        last_gnt <= gnt_idx;
        if (!req_we[gnt_idx]) rsp_valid[gnt_idx] <= 1'b1;
`ifdef DMEM_ARB_LOCK_EN
        case (state)
          IDLE: begin
            if (req_lock[gnt_idx]) begin
              state <= LOCKED;
              owner <= gnt_idx;
            end
          end
          LOCKED: begin
            if (!req_lock[gnt_idx]) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
`endif
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a 2-requester and a 4-requester instance share stimulus.
// Lock scenario is compiled in only when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic arst_n = 1'b0;

  logic [3:0]   v, we;
  logic [127:0] addr, wdata;
  logic [15:0]  mask;
`ifdef DMEM_ARB_LOCK_EN
  logic [3:0]   lk;
`endif

  logic [1:0]  gnt2, rv2;
  logic [31:0] rdata2, maddr2, mwdata2, mrdata2;
  logic        mwe2;
  logic [3:0]  mmask2;

  logic [3:0]  gnt4, rv4;
  logic [31:0] rdata4, maddr4, mwdata4, mrdata4;
  logic        mwe4;
  logic [3:0]  mmask4;

  logic [31:0] mem2 [16];
  logic [31:0] mem4 [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .NUM_REQ(2)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(v[1:0]), .req_addr(addr[63:0]), .req_wdata(wdata[63:0]),
    .req_we(we[1:0]), .req_mask(mask[7:0]),
`ifdef DMEM_ARB_LOCK_EN
    .req_lock(lk[1:0]),
`endif
    .req_gnt(gnt2), .rsp_valid(rv2), .rsp_rdata(rdata2),
    .mem_addr(maddr2), .mem_wdata(mwdata2), .mem_we(mwe2), .mem_mask(mmask2),
    .mem_rdata(mrdata2)
  );

  dmem_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4)) dut4 (
    .clk(clk), .arst_n(arst_n),
    .req_valid(v), .req_addr(addr), .req_wdata(wdata),
    .req_we(we), .req_mask(mask),
`ifdef DMEM_ARB_LOCK_EN
    .req_lock(lk),
`endif
    .req_gnt(gnt4), .rsp_valid(rv4), .rsp_rdata(rdata4),
    .mem_addr(maddr4), .mem_wdata(mwdata4), .mem_we(mwe4), .mem_mask(mmask4),
    .mem_rdata(mrdata4)
  );

  // Behavioural synchronous-read memories attached to each instance.
  initial for (int i = 0; i < 16; i++) begin mem2[i] = '0; mem4[i] = '0; end

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mwe2 && mmask2[b]) mem2[maddr2[5:2]][8*b +: 8] <= mwdata2[8*b +: 8];
    mrdata2 <= mem2[maddr2[5:2]];
  end

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mwe4 && mmask4[b]) mem4[maddr4[5:2]][8*b +: 8] <= mwdata4[8*b +: 8];
    mrdata4 <= mem4[maddr4[5:2]];
  end

  task automatic clear_reqs();
    v = '0; we = '0; addr = '0; wdata = '0; mask = '0;
`ifdef DMEM_ARB_LOCK_EN
    lk = '0;
`endif
  endtask

  task automatic set_req(input int i, input logic vv, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    v[i] = vv; we[i] = w; addr[i*32 +: 32] = a; wdata[i*32 +: 32] = d; mask[i*4 +: 4] = m;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_reqs();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_reqs();
    arst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 32'h0000_0004 * i + 32'h8, 32'hA5A5_0000 + i, 4'hF);
    #2;
    checks++; if (gnt2 !== 2'b00)   begin errors++; $display("FAIL reset_gnt2: got %b expected 00", gnt2); end
    checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL reset_gnt4: got %b expected 0000", gnt4); end
    checks++; if (mwe2 !== 1'b0)    begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mwe2); end
    checks++; if (maddr2 !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", maddr2); end
    checks++; if (mmask2 !== 4'h0)  begin errors++; $display("FAIL reset_mem_mask: got %h expected 0", mmask2); end
    @(posedge clk); #1;
    checks++; if (rv2 !== 2'b00)    begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rv2); end
    checks++; if (mwdata2 !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mwdata2); end
    clear_reqs();
    #1 arst_n = 1'b1;
    next_cycle();
  endtask

  // Reference model: grant = first valid requester at distance 1..n from the last winner.
  task automatic test_random(input int cycles);
    int          last [2];
    bit          pv [2];
    int          pi [2];
    logic [31:0] pd [2];
    logic [31:0] rm [2][16];
    int          n, e, j;
    logic [3:0]  og, orv, eg, erv, om, em;
    logic [31:0] ord, oa, owd, ea, ewd;
    logic        owe, ewe;
    do_reset();
    last[0] = 1; last[1] = 3;
    for (int d = 0; d < 2; d++) begin
      pv[d] = 1'b0; pi[d] = 0; pd[d] = '0;
      for (int i = 0; i < 16; i++) rm[d][i] = '0;
    end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 4; i++)
        set_req(i, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'($urandom));
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n = (d == 1) ? 4 : 2;
        e = -1;
        for (int k = 1; k <= n; k++) begin
          j = (last[d] + k) % n;
          if (e < 0 && v[j]) e = j;
        end
        og  = (d == 1) ? gnt4   : {2'b00, gnt2};
        orv = (d == 1) ? rv4    : {2'b00, rv2};
        ord = (d == 1) ? rdata4 : rdata2;
        owe = (d == 1) ? mwe4   : mwe2;
        oa  = (d == 1) ? maddr4 : maddr2;
        owd = (d == 1) ? mwdata4 : mwdata2;
        om  = (d == 1) ? mmask4 : mmask2;
        eg  = (e >= 0) ? 4'(1 << e) : 4'b0000;
        ea  = (e >= 0) ? addr[e*32 +: 32]  : 32'h0;
        ewd = (e >= 0) ? wdata[e*32 +: 32] : 32'h0;
        ewe = (e >= 0) ? we[e] : 1'b0;
        em  = (e >= 0) ? mask[e*4 +: 4] : 4'h0;
        erv = pv[d] ? 4'(1 << pi[d]) : 4'b0000;
        checks++; if (og !== eg)   begin errors++; $display("FAIL rand_gnt n=%0d cyc=%0d: got %b expected %b", n, c, og, eg); end
        checks++; if (owe !== ewe) begin errors++; $display("FAIL rand_mem_we n=%0d cyc=%0d: got %b expected %b", n, c, owe, ewe); end
        checks++; if (oa !== ea)   begin errors++; $display("FAIL rand_mem_addr n=%0d cyc=%0d: got %h expected %h", n, c, oa, ea); end
        checks++; if (owd !== ewd) begin errors++; $display("FAIL rand_mem_wdata n=%0d cyc=%0d: got %h expected %h", n, c, owd, ewd); end
        checks++; if (om !== em)   begin errors++; $display("FAIL rand_mem_mask n=%0d cyc=%0d: got %h expected %h", n, c, om, em); end
        checks++; if (orv !== erv) begin errors++; $display("FAIL rand_rsp_valid n=%0d cyc=%0d: got %b expected %b", n, c, orv, erv); end
        if (pv[d]) begin
          checks++; if (ord !== pd[d]) begin errors++; $display("FAIL rand_rsp_rdata n=%0d cyc=%0d: got %h expected %h", n, c, ord, pd[d]); end
        end
        pv[d] = 1'b0;
        if (e >= 0) begin
          last[d] = e;
          if (ewe) begin
            for (int b = 0; b < 4; b++)
              if (em[b]) rm[d][ea[5:2]][8*b +: 8] = ewd[8*b +: 8];
          end else begin
            pv[d] = 1'b1; pi[d] = e; pd[d] = rm[d][ea[5:2]];
          end
        end
      end
      next_cycle();
    end
    clear_reqs();
  endtask

  task automatic test_back_to_back();
    logic [1:0] eg [3];
    logic [1:0] erv [5];
    eg[0] = 2'b01; eg[1] = 2'b10; eg[2] = 2'b01;
    erv[0] = 2'b00; erv[1] = 2'b01; erv[2] = 2'b10; erv[3] = 2'b01; erv[4] = 2'b00;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        set_req(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
      end else clear_reqs();
      @(negedge clk);
      if (c < 3) begin
        checks++; if (gnt2 !== eg[c]) begin errors++; $display("FAIL b2b_gnt cyc=%0d: got %b expected %b", c, gnt2, eg[c]); end
      end
      checks++; if (rv2 !== erv[c]) begin errors++; $display("FAIL b2b_rsp_valid cyc=%0d: got %b expected %b", c, rv2, erv[c]); end
      next_cycle();
    end
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b expected 01", gnt2); end
    checks++; if (mwe2 !== 1'b1 || maddr2 !== 32'h10 || mwdata2 !== 32'hDEAD_BEEF || mmask2 !== 4'hF) begin
      errors++; $display("FAIL wr_mem_port: got we=%b addr=%h data=%h mask=%h expected 1/10/deadbeef/f", mwe2, maddr2, mwdata2, mmask2);
    end
    next_cycle();
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL wr_no_rsp: got %b expected 00", rv2); end
    checks++; if (gnt2 !== 2'b10 || mwe2 !== 1'b0) begin errors++; $display("FAIL rd_gnt: got gnt=%b we=%b expected 10/0", gnt2, mwe2); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    checks++; if (rv2 !== 2'b10) begin errors++; $display("FAIL rd_rsp_valid: got %b expected 10", rv2); end
    checks++; if (rdata2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp_rdata: got %h expected deadbeef", rdata2); end
    next_cycle();
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      clear_reqs();
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b1, 32'h3C, 32'hFFFF_FFFF, 4'hF);
      @(negedge clk);
      checks++; if (gnt2 !== 2'b00 || rv2 !== 2'b00) begin errors++; $display("FAIL idle_gnt_rsp: got gnt=%b rsp=%b expected 00/00", gnt2, rv2); end
      checks++; if (mwe2 !== 1'b0 || mmask2 !== 4'h0 || maddr2 !== 32'h0 || mwdata2 !== 32'h0) begin
        errors++; $display("FAIL idle_mem_port: got we=%b mask=%h addr=%h data=%h expected zeros", mwe2, mmask2, maddr2, mwdata2);
      end
      next_cycle();
    end
    clear_reqs();
  endtask

  task automatic test_reset_pending();
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL rstp_gnt: got %b expected 01", gnt2); end
    next_cycle();
    checks++; if (rv2 !== 2'b01) begin errors++; $display("FAIL rstp_rsp_before: got %b expected 01", rv2); end
    clear_reqs();
    arst_n = 1'b0;
    #1;
    checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL rstp_rsp_cleared: got %b expected 00", rv2); end
    @(negedge clk);
    arst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL rstp_rsp_after: got %b expected 00", rv2); end
    next_cycle();
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL rstp_first_gnt: got %b expected 01", gnt2); end
    next_cycle();
    clear_reqs();
  endtask

  task automatic test_rr4();
    logic [3:0] eg [5];
    eg[0] = 4'b0001; eg[1] = 4'b0010; eg[2] = 4'b0100; eg[3] = 4'b1000; eg[4] = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 32'h4 * i, 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (gnt4 !== eg[c]) begin errors++; $display("FAIL rr4_gnt cyc=%0d: got %b expected %b", c, gnt4, eg[c]); end
      if (c > 0) begin
        checks++; if (rv4 !== eg[c-1]) begin errors++; $display("FAIL rr4_rsp_valid cyc=%0d: got %b expected %b", c, rv4, eg[c-1]); end
      end
      next_cycle();
    end
    clear_reqs();
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0); lk = 4'b0010;
    @(negedge clk);
    checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL lock_rd_gnt: got %b expected 10", gnt2); end
    next_cycle();
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (gnt2 !== 2'b00) begin errors++; $display("FAIL lock_owner_only: got %b expected 00", gnt2); end
    checks++; if (rv2 !== 2'b10) begin errors++; $display("FAIL lock_rd_rsp: got %b expected 10", rv2); end
    next_cycle();
    set_req(1, 1'b1, 1'b1, 32'h24, 32'h1234_5678, 4'hF); lk = 4'b0010;
    @(negedge clk);
    checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL lock_wr_gnt: got %b expected 10", gnt2); end
    next_cycle();
    lk = 4'b0000;
    @(negedge clk);
    checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL unlock_wr_gnt: got %b expected 10", gnt2); end
    next_cycle();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL lock_release_gnt: got %b expected 01", gnt2); end
    next_cycle();
    clear_reqs();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_reqs();
    #3;
    test_reset();
    test_random(300);
    test_back_to_back();
    test_write_read();
    test_idle();
    test_reset_pending();
    test_rr4();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the address and data width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 2, the number of requesters; legal range 2..4.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port arst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester access request.
REQ-006 SHALL have port req_addr  input  NUM_REQ x DATA_WIDTH  per-requester byte address.
REQ-007 SHALL have port req_wdata  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-008 SHALL have port req_we  input  NUM_REQ  per-requester write enable.
REQ-009 SHALL have port req_mask  input  NUM_REQ x DATA_WIDTH/8  per-requester byte mask.
REQ-010 SHALL have port req_gnt  output  NUM_REQ  one-hot grant, same cycle as the request.
REQ-011 SHALL have port rsp_valid  output  NUM_REQ  read data valid for requester i.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, shared by all requesters.
REQ-013 SHALL have ports mem_addr, mem_wdata, mem_we and mem_mask  output  DATA_WIDTH / DATA_WIDTH / 1 / DATA_WIDTH/8  shared memory port.
REQ-014 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data, one-cycle synchronous read.

Function
REQ-015 SHALL assert at most one req_gnt bit per cycle; req_gnt[i] implies req_valid[i].
REQ-016 SHALL grant combinationally: any req_valid high produces a grant in the same cycle (zero wait when uncontended).
REQ-017 SHALL arbitrate round-robin: the search starts at (last_gnt+1) mod NUM_REQ and wraps; last_gnt updates on every grant.
REQ-018 SHALL drive mem_addr, mem_wdata, mem_we and mem_mask from the granted requester in the same cycle.
REQ-019 SHALL drive all mem_* outputs to 0 when there is no grant (no spurious write).
REQ-020 SHALL pulse rsp_valid[i] for exactly one cycle, one cycle after a granted read (we=0) by requester i, with rsp_rdata = mem_rdata.
REQ-021 SHALL raise no rsp_valid for writes; a write completes on its grant cycle.
REQ-022 SHALL support back-to-back grants every cycle; a read response and a new grant in the same cycle are independent.
REQ-023 SHALL, for an ungranted requester, tolerate it holding valid and payload stable indefinitely; it is not starved beyond NUM_REQ-1 grants to others (unlocked mode).

Reset
REQ-024 SHALL, on arst_n low, immediately clear req_gnt, rsp_valid, all mem_* outputs and the lock state, and set last_gnt = NUM_REQ-1 so requester 0 wins first.
REQ-025 SHALL discard a read response pending at reset; no rsp_valid after reset release without a new grant.

Configuration
REQ-026 SHALL support the macro DMEM_ARB_LOCK_EN, which enables a req_lock input (NUM_REQ bits) and the states IDLE and LOCKED.
REQ-027 SHALL, with DMEM_ARB_LOCK_EN defined, move IDLE->LOCKED on a grant to i with req_lock[i]=1 and record owner=i; in LOCKED only the owner is grantable; LOCKED->IDLE on an owner grant with req_lock=0; last_gnt still updates.
REQ-028 SHALL, with DMEM_ARB_LOCK_EN undefined, omit the req_lock port and remain permanently in IDLE, with pure round-robin behaviour.

Verification
REQ-029 SHALL verify: after reset, req_valid=2'b11, both reads -> gnt 01, then 10, then 01 on consecutive cycles; each rsp_valid one cycle after its grant.
REQ-030 SHALL verify: req0 writes addr 0x10, data 0xDEADBEEF, mask 0xF, then req1 reads 0x10 -> req1 gets rsp_valid with rsp_rdata 0xDEADBEEF.
REQ-031 SHALL verify: no requests -> mem_we=0, mem_mask=0, mem_addr=0, no rsp_valid.
REQ-032 SHALL verify: arst_n pulsed low in the cycle after a granted read -> rsp_valid stays 0; the next grant goes to requester 0.
REQ-033 SHALL verify, with DMEM_ARB_LOCK_EN: req1 locked read, then locked write, then unlocked write while req0 is valid throughout -> req0 is granted only after req1's unlocked write.
REQ-034 SHALL verify: NUM_REQ=4 with all valid -> grant order 0,1,2,3,0 with no repeats.
